// File: rtl/matrix_dma_master.sv
// matrix_dma_master: bus-initiator that copies A/B into the accelerator,
// runs it, polls STATUS and copies C back to RAM; done pulses at job end.
// Ports: clk, rst_n (sync, active-low), start, src_a_addr, src_b_addr,
//   dst_c_addr, busy, done, error, mem_valid/ready/addr/wdata/wstrb/rdata.
// Optional: MDMA_TIMEOUT_EN bounds POLL to TIMEOUT_CYCLES and sets error.
module matrix_dma_master #(
  parameter int unsigned M              = 4,
  parameter int unsigned N              = 4,
  parameter int unsigned P              = 4,
  parameter logic [31:0] ACCEL_BASE     = 32'h1000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] src_a_addr,
  input  logic [31:0] src_b_addr,
  input  logic [31:0] dst_c_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned NA = M * N;
  localparam int unsigned NB = N * P;
  localparam int unsigned NC = M * P;
  localparam int unsigned NAB = (NA > NB) ? NA : NB;
  localparam int unsigned NMAX = (NAB > NC) ? NAB : NC;
  localparam int unsigned IW = $clog2(NMAX) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [31:0] ACC = {ACCEL_BASE[31:2], 2'b00};
  localparam logic [31:0] B_OFF = 32'h0000_0040;
  localparam logic [31:0] C_OFF = 32'h0000_0080;
  localparam logic [31:0] CTRL_OFF = 32'h0000_0100;
  localparam logic [31:0] STAT_OFF = 32'h0000_0104;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_A,
    S_WR_A,
    S_RD_B,
    S_WR_B,
    S_ACC_RST,
    S_ACC_GO,
    S_POLL,
    S_RD_C,
    S_WR_C,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   a_base_q, b_base_q, c_base_q;
  logic [31:0]   data_q;
  logic [TW-1:0] poll_q;
  logic [31:0]   off;
  logic          accept;
  logic          cap;
  logic          last_a, last_b, last_c;

  assign off    = 32'(idx_q) << 2;
  assign last_a = (idx_q == IW'(NA - 1));
  assign last_b = (idx_q == IW'(NB - 1));
  assign last_c = (idx_q == IW'(NC - 1));

`ifdef MDMA_TIMEOUT_EN
  logic set_err;
  logic error_q;
  logic tmo_hit;

  assign tmo_hit = (poll_q >= TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mem_valid = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
    accept    = 1'b0;
    cap       = 1'b0;
`ifdef MDMA_TIMEOUT_EN
    set_err   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        mem_valid = 1'b1;
        mem_addr  = a_base_q + off;
        if (mem_ready) begin
          cap     = 1'b1;
          state_d = S_WR_A;
        end
      end
      S_WR_A: begin
        mem_valid = 1'b1;
        mem_addr  = ACC + off;
        mem_wdata = data_q;
        mem_wstrb = 4'hF;
        if (mem_ready) begin
          if (last_a) begin
            idx_d   = '0;
            state_d = S_RD_B;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_RD_A;
          end
        end
      end
      S_RD_B: begin
        mem_valid = 1'b1;
        mem_addr  = b_base_q + off;
        if (mem_ready) begin
          cap     = 1'b1;
          state_d = S_WR_B;
        end
      end
      S_WR_B: begin
        mem_valid = 1'b1;
        mem_addr  = ACC + B_OFF + off;
        mem_wdata = data_q;
        mem_wstrb = 4'hF;
        if (mem_ready) begin
          if (last_b) begin
            idx_d   = '0;
            state_d = S_ACC_RST;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_RD_B;
          end
        end
      end
      S_ACC_RST: begin
        // clears a done flag left over from a previous run
        mem_valid = 1'b1;
        mem_addr  = ACC + CTRL_OFF;
        mem_wdata = 32'h2;
        mem_wstrb = 4'hF;
        if (mem_ready) state_d = S_ACC_GO;
      end
      S_ACC_GO: begin
        mem_valid = 1'b1;
        mem_addr  = ACC + CTRL_OFF;
        mem_wdata = 32'h1;
        mem_wstrb = 4'hF;
        if (mem_ready) state_d = S_POLL;
      end
      S_POLL: begin
        mem_valid = 1'b1;
        mem_addr  = ACC + STAT_OFF;
        if (mem_ready) begin
          if (mem_rdata[1]) begin
            idx_d   = '0;
            state_d = S_RD_C;
          end
`ifdef MDMA_TIMEOUT_EN
          else if (tmo_hit) begin
            set_err = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_RD_C: begin
        mem_valid = 1'b1;
        mem_addr  = ACC + C_OFF + off;
        if (mem_ready) begin
          cap     = 1'b1;
          state_d = S_WR_C;
        end
      end
      S_WR_C: begin
        mem_valid = 1'b1;
        mem_addr  = c_base_q + off;
        mem_wdata = data_q;
        mem_wstrb = 4'hF;
        if (mem_ready) begin
          if (last_c) begin
            idx_d   = '0;
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_RD_C;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      a_base_q <= 32'h0;
      b_base_q <= 32'h0;
      c_base_q <= 32'h0;
      data_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        a_base_q <= {src_a_addr[31:2], 2'b00};
        b_base_q <= {src_b_addr[31:2], 2'b00};
        c_base_q <= {dst_c_addr[31:2], 2'b00};
      end
      // registered so the next write never sees rdata combinationally
      if (cap) data_q <= mem_rdata;
    end
  end

  // counts cycles spent in POLL; zero on the entry cycle, saturating
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      poll_q <= '0;
    end else if (state_q != S_POLL) begin
      poll_q <= '0;
    end else if (poll_q != TW'(TIMEOUT_CYCLES)) begin
      poll_q <= poll_q + TW'(1);
    end
  end

`ifdef MDMA_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else if (accept) begin
      error_q <= 1'b0;
    end else if (set_err) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_matrix_dma_master.sv
// tb_matrix_dma_master: directed bench with RAM + behavioural accelerator
// model; checks C copy-back, control sequence, polling, start and reset.
module tb_matrix_dma_master;

  localparam logic [31:0] AB = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_a_addr = 32'h0;
  logic [31:0] src_b_addr = 32'h0;
  logic [31:0] dst_c_addr = 32'h0;
  logic        busy, done, error;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  matrix_dma_master #(
    .M(4), .N(4), .P(4),
    .ACCEL_BASE(AB),
    .TIMEOUT_CYCLES(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
    .dst_c_addr(dst_c_addr),
    .busy(busy), .done(done), .error(error),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  logic [31:0] ram [0:1023];
  logic [31:0] acc_a [0:15];
  logic [31:0] acc_b [0:15];
  logic [31:0] acc_c [0:15];
  logic        acc_done = 1'b0;
  logic        acc_run = 1'b0;
  int          acc_cnt = 0;
  logic        acc_never = 1'b0;
  logic        load_ram = 1'b0;
  logic        rand_rdy = 1'b0;
  logic        rdy_r = 1'b1;

  int beats = 0, stat_reads = 0, stat_pend = 0, c_rd = 0;
  int done_cnt = 0, stab_viol = 0, misalign = 0, bad_strb = 0;
  int alt_hits = 0, ctl_n = 0;
  logic [31:0] ctl_data [0:15];
  logic [3:0]  ctl_strb [0:15];
  logic        hold = 1'b0;
  logic [67:0] held = '0;
  logic [31:0] sum;

  assign mem_ready = rand_rdy ? rdy_r : 1'b1;

  always @(negedge clk) rdy_r <= 1'($urandom_range(0, 1));

  always_comb begin
    logic [31:0] o;
    mem_rdata = 32'h0;
    o = mem_addr - AB;
    if (mem_addr < AB) mem_rdata = ram[mem_addr[11:2]];
    else if (o < 32'h40) mem_rdata = acc_a[o[5:2]];
    else if (o < 32'h80) mem_rdata = acc_b[o[5:2]];
    else if (o < 32'hC0) mem_rdata = acc_c[o[5:2]];
    else if (o == 32'h104) mem_rdata = {30'h0, acc_done, 1'b0};
  end

  always @(posedge clk) begin
    logic [31:0] o;
    o = mem_addr - AB;
    if (load_ram) begin
      for (int k = 0; k < 1024; k++) ram[k] <= 32'h0;
      for (int k = 0; k < 16; k++) ram[64 + k] <= 32'(k + 1);
      for (int k = 0; k < 4; k++) ram[128 + k * 5] <= 32'h1;
    end
    if (acc_run) begin
      if (acc_cnt == 1) begin
        acc_done <= 1'b1;
        acc_run  <= 1'b0;
      end
      acc_cnt <= acc_cnt - 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (rst_n) begin
      if (mem_valid && mem_addr[1:0] != 2'b00) misalign <= misalign + 1;
      if (hold && mem_valid && {mem_addr, mem_wdata, mem_wstrb} != held)
        stab_viol <= stab_viol + 1;
      hold <= mem_valid && !mem_ready;
      held <= {mem_addr, mem_wdata, mem_wstrb};
      if (mem_valid && mem_ready) begin
        beats <= beats + 1;
        if (mem_addr >= 32'h500 && mem_addr < 32'h800)
          alt_hits <= alt_hits + 1;
        if (mem_wstrb == 4'hF) begin
          if (mem_addr < AB) ram[mem_addr[11:2]] <= mem_wdata;
          else if (o < 32'h40) acc_a[o[5:2]] <= mem_wdata;
          else if (o < 32'h80) acc_b[o[5:2]] <= mem_wdata;
          else if (o == 32'h100) begin
            if (ctl_n < 16) begin
              ctl_data[ctl_n] <= mem_wdata;
              ctl_strb[ctl_n] <= mem_wstrb;
            end
            ctl_n <= ctl_n + 1;
            if (mem_wdata == 32'h2) begin
              acc_done <= 1'b0;
              acc_run  <= 1'b0;
            end else if (mem_wdata == 32'h1) begin
              for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                  sum = 32'h0;
                  for (int k = 0; k < 4; k++)
                    sum = sum + acc_a[r * 4 + k] * acc_b[k * 4 + c];
                  acc_c[r * 4 + c] <= sum;
                end
              acc_cnt <= 20;
              acc_run <= !acc_never;
            end
          end
        end else begin
          if (mem_wstrb != 4'h0) bad_strb <= bad_strb + 1;
          if (o == 32'h104) begin
            stat_reads <= stat_reads + 1;
            if (!acc_done) stat_pend <= stat_pend + 1;
          end
          if (o >= 32'h80 && o < 32'hC0) c_rd <= c_rd + 1;
        end
      end
    end else begin
      hold <= 1'b0;
    end
  end

  int checks = 0;
  int passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic pulse_load;
    load_ram = 1'b1;
    @(negedge clk);
    load_ram = 1'b0;
  endtask

  function automatic int c_errs(input int base);
    int e = 0;
    for (int k = 0; k < 16; k++)
      if (ram[base + k] !== 32'(k + 1)) e++;
    return e;
  endfunction

  task automatic run_job(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input bit inject,
                         output bit got, output int gaps,
                         output logic after);
    int cyc = 0;
    bit inj = 0;
    got = 0;
    gaps = 0;
    src_a_addr = a;
    src_b_addr = b;
    dst_c_addr = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!got && cyc < 20000) begin
      if (!busy) gaps++;
      if (done) begin
        got = 1;
      end else begin
        if (inject && !inj && mem_valid && mem_wstrb == 4'h0 &&
            mem_addr == b) begin
          start = 1'b1;
          src_a_addr = 32'h500;
          src_b_addr = 32'h600;
          dst_c_addr = 32'h700;
          inj = 1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    @(negedge clk);
    after = busy;
  endtask

  initial begin
    bit got;
    int gaps;
    logic after;
    int b0, sp0, sr0, cn0, d0, al0, cr0, wt;

    for (int k = 0; k < 16; k++) begin
      acc_a[k] = 32'h0;
      acc_b[k] = 32'h0;
      acc_c[k] = 32'h0;
    end
    @(negedge clk);
    pulse_load();
    @(negedge clk);
    chk("rst_valid", {31'h0, mem_valid}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_error", {31'h0, error}, 32'h0);
    chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // job 1: zero-wait, full accounting
    b0 = beats; sp0 = stat_pend; cn0 = ctl_n; d0 = done_cnt;
    run_job(32'h100, 32'h200, 32'h300, 0, got, gaps, after);
    chk("j1_done_seen", {31'h0, got}, 32'h1);
    chk("j1_busy_span", gaps, 32'h0);
    chk("j1_busy_after", {31'h0, after}, 32'h0);
    chk("j1_error", {31'h0, error}, 32'h0);
    chk("j1_done_cnt", done_cnt - d0, 32'h1);
    chk("j1_beats", beats - b0, 32'd119);
    chk("j1_pending_polls", stat_pend - sp0, 32'd20);
    chk("j1_ctl_count", ctl_n - cn0, 32'h2);
    chk("j1_ctl0_data", ctl_data[cn0], 32'h2);
    chk("j1_ctl0_strb", {28'h0, ctl_strb[cn0]}, 32'hF);
    chk("j1_ctl1_data", ctl_data[cn0 + 1], 32'h1);
    chk("j1_ctl1_strb", {28'h0, ctl_strb[cn0 + 1]}, 32'hF);
    for (int k = 0; k < 16; k++)
      chk($sformatf("j1_c%0d", k), ram[192 + k], 32'(k + 1));

    // job 2: random backpressure, unaligned destination
    pulse_load();
    rand_rdy = 1'b1;
    d0 = done_cnt;
    run_job(32'h100, 32'h200, 32'h302, 0, got, gaps, after);
    rand_rdy = 1'b0;
    chk("j2_done_seen", {31'h0, got}, 32'h1);
    chk("j2_busy_span", gaps, 32'h0);
    chk("j2_done_cnt", done_cnt - d0, 32'h1);
    chk("j2_c_errs", c_errs(192), 32'h0);
    chk("j2_stable", stab_viol, 32'h0);

    // job 3: second start during RD_B is ignored
    pulse_load();
    d0 = done_cnt; al0 = alt_hits;
    run_job(32'h100, 32'h200, 32'h300, 1, got, gaps, after);
    repeat (3) @(negedge clk);
    chk("j3_done_seen", {31'h0, got}, 32'h1);
    chk("j3_done_cnt", done_cnt - d0, 32'h1);
    chk("j3_alt_hits", alt_hits - al0, 32'h0);
    chk("j3_c_errs", c_errs(192), 32'h0);
    chk("j3_idle", {31'h0, busy}, 32'h0);

    // reset while writing A[2]
    pulse_load();
    src_a_addr = 32'h100;
    src_b_addr = 32'h200;
    dst_c_addr = 32'h300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wt = 0;
    while (!(mem_valid && mem_wstrb == 4'hF && mem_addr == AB + 32'h8) &&
           wt < 200) begin
      @(negedge clk);
      wt++;
    end
    chk("rwa_reached", {31'h0, wt < 200}, 32'h1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rwa_valid", {31'h0, mem_valid}, 32'h0);
    chk("rwa_busy", {31'h0, busy}, 32'h0);
    chk("rwa_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    run_job(32'h100, 32'h200, 32'h300, 0, got, gaps, after);
    chk("rwa_job_done", {31'h0, got}, 32'h1);
    chk("rwa_done_cnt", done_cnt - d0, 32'h1);
    chk("rwa_c_errs", c_errs(192), 32'h0);

`ifdef MDMA_TIMEOUT_EN
    // accelerator never finishes
    pulse_load();
    acc_never = 1'b1;
    d0 = done_cnt; cr0 = c_rd; sr0 = stat_reads;
    run_job(32'h100, 32'h200, 32'h300, 0, got, gaps, after);
    chk("tmo_done_seen", {31'h0, got}, 32'h1);
    chk("tmo_error", {31'h0, error}, 32'h1);
    chk("tmo_done_cnt", done_cnt - d0, 32'h1);
    chk("tmo_polls", stat_reads - sr0, 32'd64);
    chk("tmo_no_rdc", c_rd - cr0, 32'h0);
    chk("tmo_no_wrc", ram[192], 32'h0);
    acc_never = 1'b0;
    run_job(32'h100, 32'h200, 32'h300, 0, got, gaps, after);
    chk("tmo_clear_err", {31'h0, error}, 32'h0);
    chk("tmo_next_c", c_errs(192), 32'h0);
`endif

    chk("misaligned", misalign, 32'h0);
    chk("bad_wstrb", bad_strb, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
